sync_fifo: RTL
==============

Name: sync_fifo

Overview:
- Single-clock, show-ahead FIFO that buffers a WIDTH-bit value stream between a producer and a consumer running at different rates.
- Typical use: upstream of Register/Prev/Delay primitives. It absorbs bursts so a downstream register stage can capture values on its own write_en schedule.
- Storage is a DEPTH-entry memory with read/write pointers and an occupancy counter.
- Status and error flags are registered.

Parameters:
- WIDTH, 32: data width in bits; must be ≥ 1.
- DEPTH, 4: number of entries; must be ≥ 2 and need not be a power of two.
- SAFE, 1: 1 = out driven to 0 while empty; 0 = out is 'x while empty (mirrors Prev SAFE semantics).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  write request; in is captured on this cycle's posedge if accepted.
- in  input  WIDTH  write data.
- full  output  1  registered; 1 when count == DEPTH.
- pop  input  1  read request; removes the head entry at posedge if accepted.
- out  output  WIDTH  head entry (show-ahead); combinational read of mem[rd_ptr].
- empty  output  1  registered; 1 when count == 0.
- count  output  $clog2(DEPTH+1)  registered occupancy, 0..DEPTH.
- overflow  output  1  sticky; set by a push that is rejected.
- underflow  output  1  sticky; set by a pop that is rejected.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset and has priority over all other inputs.
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0, empty = 1, full = 0, overflow = 0, underflow = 0. out follows the SAFE rule. Memory contents are not cleared.
- Reset mid-operation discards all stored entries; no push or pop in the reset cycle takes effect.
- Accept rules, evaluated on pre-edge state:
  - push_ok = push & (!full | pop_ok)
  - pop_ok = pop & !empty
- Empty with push and pop together: the pop is rejected (no bypass) and sets underflow. The push is accepted, and count goes 0 → 1.
- Full with push and pop together: both are accepted. count stays at DEPTH and full stays 1.
- Full with push and no pop: the push is rejected and overflow sets. Storage and pointers are unchanged.
- Empty with pop and no push: the pop is rejected and underflow sets.
- On push_ok: mem[wr_ptr] <= in; wr_ptr advances by 1, wrapping from DEPTH-1 to 0 (explicit compare, not bit truncation).
- On pop_ok: rd_ptr advances with the same wrap rule.
- count update: count <= count + push_ok - pop_ok.
  - empty <= (next count == 0)
  - full <= (next count == DEPTH)
- Latency: a value pushed at edge N appears on out in the cycle after edge N, provided it is at the head. empty deasserts in that same cycle.
- out:
  - when !empty, out = mem[rd_ptr] and is stable until the next pop_ok;
  - when empty, out = 0 (SAFE = 1) or 'x (SAFE = 0).
- Ordering: strict FIFO, with no reordering or loss of accepted data.
- overflow and underflow stay set until reset.
- Invariants (for assertions):
  - full & empty never both 1;
  - count == (wr_ptr - rd_ptr) mod DEPTH, except when full.

Test Plan:
- WIDTH=8, DEPTH=4, after reset → empty=1, full=0, count=0, out=0, flags=0.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles → count 1, 2, 3, 4; full=1 after 4th edge; out=0x11 throughout.
- Continue from the full state: push 0x55 alone → overflow=1, count=4. Then pop four times → out reads 0x11, 0x22, 0x33, 0x44; empty=1 afterwards; 0x55 is never seen.
- From empty, push 0xA0 and pop in the same cycle → underflow=1, count=1, out=0xA0 next cycle.
- Fill to 4, then push+pop simultaneously 6 cycles with 0x60..0x65 → count stays 4; out sequence starts with the original head; pointers wrap twice; drained order is exactly the push order.
- Mid-stream reset at count=3 → next cycle count=0, empty=1, flags=0. A push in the reset cycle is not stored.

Source files
------------

// File: rtl/sync_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_if
//  Purpose  : Producer/consumer bundle for sync_fifo. The master side drives
//             push/in/pop; the slave side (the FIFO) returns data and status.
//  Revision : 1.0 - initial release
// ============================================================================
interface sync_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             push;
  logic [WIDTH-1:0] in;
  logic             full;
  logic             pop;
  logic [WIDTH-1:0] out;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  // Producer/consumer side
  modport master (
    output push, in, pop,
    input  full, out, empty, count, overflow, underflow
  );

  // FIFO side
  modport slave (
    input  push, in, pop,
    output full, out, empty, count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock show-ahead FIFO with registered status, occupancy
//             counter and sticky overflow/underflow flags. DEPTH need not be a
//             power of two; pointers wrap by explicit compare.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter bit SAFE  = 1'b1
) (
  input  wire logic    clk,
  input  wire logic    reset,
  sync_fifo_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q;
  logic             full_q;
  logic             overflow_q;
  logic             underflow_q;

  logic push_ok;
  logic pop_ok;

  // Accept decisions use pre-edge state; a pop frees a slot for a push when full,
  // but an empty FIFO never bypasses a same-cycle push to the reader.
  assign pop_ok  = bus.pop & ~empty_q;
  assign push_ok = bus.push & (~full_q | pop_ok);

  // Next-state pointers (wrap at DEPTH-1) and occupancy
  always_comb begin
    wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Storage write; contents are deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr_q] <= bus.in;
    end
  end

  // Pointer, occupancy, status and sticky error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_d;
      if (pop_ok)  rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_W'(DEPTH));
      if (bus.push && !push_ok) overflow_q  <= 1'b1;
      if (bus.pop  && !pop_ok)  underflow_q <= 1'b1;
    end
  end

  // Head-of-queue output; SAFE selects what an empty FIFO presents
  generate
    if (SAFE) begin : g_safe_out
      assign bus.out = empty_q ? '0 : mem[rd_ptr_q];
    end else begin : g_raw_out
      assign bus.out = empty_q ? 'x : mem[rd_ptr_q];
    end
  endgenerate

  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

  // Structural invariants
  a_not_full_and_empty : assert property (@(posedge clk) disable iff (reset)
    !(full_q && empty_q));

  a_count_matches_ptrs : assert property (@(posedge clk) disable iff (reset)
    full_q || (((int'(wr_ptr_q) - int'(rd_ptr_q) + DEPTH) % DEPTH) == int'(count_q)));

endmodule
`default_nettype wire
